reg_ctx_transfer_ctrl: RTL and testbench

- Sequences whole-register-file spill (SAVE) and fill (RESTORE) between the CPU register file and the register-memory, for one of NUM_CTX context slots.
- Walks every register index with an FSM and handshakes each word with the memory using MEM_BUSYWAIT.
- Stalls the pipeline via BUSYWAIT until the transfer completes, then pulses DONE.
- Replaces the fixed-delay, single-shot register memory controller with a cycle-accurate, parametrised one.

---
 rtl/reg_ctx_transfer_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_reg_ctx_transfer_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ctx_transfer_ctrl.sv
// Register-file context transfer controller.
// Spills (SAVE) or fills (RESTORE) a whole register file to or from one of
// NUM_CTX context slots in the register memory, one word at a time. Each
// memory access is handshaked with MEM_BUSYWAIT. The pipeline is stalled via
// BUSYWAIT until the transfer completes, and DONE then pulses for one cycle.
module reg_ctx_transfer_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_IDX_W  = 5,
  parameter int NUM_CTX    = 4,
  parameter int CTX_W      = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int SKIP_X0    = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SAVE_REQ,
  input  logic                  RESTORE_REQ,
  input  logic [CTX_W-1:0]      CTX_ID,
  output logic                  BUSYWAIT,
  output logic                  DONE,
  output logic                  ERR,
  output logic [REG_IDX_W-1:0]  RF_ADDR,
  input  logic [DATA_WIDTH-1:0] RF_RDATA,
  output logic                  RF_WEN,
  output logic [DATA_WIDTH-1:0] RF_WDATA,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  input  logic                  MEM_BUSYWAIT
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAVE_RD = 3'd1,
    SAVE_WR = 3'd2,
    REST_RD = 3'd3,
    REST_WR = 3'd4
  } state_t;

  // First and last register index visited by a transfer.
  localparam logic [REG_IDX_W-1:0] IDX_FIRST = REG_IDX_W'(SKIP_X0);
  localparam logic [REG_IDX_W-1:0] IDX_LAST  = REG_IDX_W'(NUM_REGS - 1);

  state_t                  state_r,  state_nx_s;
  logic [REG_IDX_W-1:0]    idx_r,    idx_nx_s;
  logic [CTX_W-1:0]        ctx_r,    ctx_nx_s;
  logic [DATA_WIDTH-1:0]   wbuf_r,   wbuf_nx_s;
  logic [DATA_WIDTH-1:0]   rbuf_r,   rbuf_nx_s;
  logic                    done_r,   done_nx_s;
  logic                    err_r,    err_nx_s;

  logic                    req_s;
  logic                    accept_s;
  logic                    ctx_bad_s;
  logic                    last_s;
  logic [ADDR_WIDTH-1:0]   addr_s;

  // A request is only taken in IDLE and never in a DONE/ERR cycle, which
  // gives the requestor one cycle to drop or change its request.
  assign req_s     = SAVE_REQ | RESTORE_REQ;
  assign accept_s  = (state_r == IDLE) & req_s & ~done_r & ~err_r;
  assign ctx_bad_s = (32'(CTX_ID) >= 32'(NUM_CTX));
  assign last_s    = (idx_r == IDX_LAST);
  assign addr_s    = ADDR_WIDTH'(ctx_r) * ADDR_WIDTH'(NUM_REGS) + ADDR_WIDTH'(idx_r);

  // State, index, context and data buffers; cleared asynchronously so a
  // partial transfer is abandoned.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= IDLE;
      idx_r   <= '0;
      ctx_r   <= '0;
      wbuf_r  <= '0;
      rbuf_r  <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      idx_r   <= idx_nx_s;
      ctx_r   <= ctx_nx_s;
      wbuf_r  <= wbuf_nx_s;
      rbuf_r  <= rbuf_nx_s;
      done_r  <= done_nx_s;
      err_r   <= err_nx_s;
    end
  end

  // Next-state logic: walk every index, one RF access and one memory
  // handshake per register.
  always_comb begin
    state_nx_s = state_r;
    idx_nx_s   = idx_r;
    ctx_nx_s   = ctx_r;
    wbuf_nx_s  = wbuf_r;
    rbuf_nx_s  = rbuf_r;
    done_nx_s  = 1'b0;
    err_nx_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (ctx_bad_s) begin
            err_nx_s = 1'b1;
          end else begin
            ctx_nx_s   = CTX_ID;
            idx_nx_s   = IDX_FIRST;
            state_nx_s = RESTORE_REQ ? REST_RD : SAVE_RD;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      SAVE_RD: begin
        wbuf_nx_s  = RF_RDATA;
        state_nx_s = SAVE_WR;
      end
      SAVE_WR: begin
        if (!MEM_BUSYWAIT) begin
          if (last_s) begin
            state_nx_s = IDLE;
            done_nx_s  = 1'b1;
          end else begin
            idx_nx_s   = idx_r + REG_IDX_W'(1);
            state_nx_s = SAVE_RD;
          end
        end else begin
          state_nx_s = SAVE_WR;
        end
      end
      REST_RD: begin
        if (!MEM_BUSYWAIT) begin
          rbuf_nx_s  = MEM_RDATA;
          state_nx_s = REST_WR;
        end else begin
          state_nx_s = REST_RD;
        end
      end
      REST_WR: begin
        if (last_s) begin
          state_nx_s = IDLE;
          done_nx_s  = 1'b1;
        end else begin
          idx_nx_s   = idx_r + REG_IDX_W'(1);
          state_nx_s = REST_RD;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Output decode from the registered state; everything idles at zero.
  always_comb begin
    BUSYWAIT  = ~RESET & ((state_r != IDLE) | accept_s);
    DONE      = done_r;
    ERR       = err_r;
    RF_ADDR   = '0;
    RF_WEN    = 1'b0;
    RF_WDATA  = '0;
    MEM_ADDR  = '0;
    MEM_READ  = 1'b0;
    MEM_WRITE = 1'b0;
    MEM_WDATA = '0;
    case (state_r)
      SAVE_RD: begin
        RF_ADDR = idx_r;
      end
      SAVE_WR: begin
        MEM_WRITE = 1'b1;
        MEM_ADDR  = addr_s;
        MEM_WDATA = wbuf_r;
      end
      REST_RD: begin
        MEM_READ = 1'b1;
        MEM_ADDR = addr_s;
      end
      REST_WR: begin
        RF_WEN   = 1'b1;
        RF_ADDR  = idx_r;
        RF_WDATA = rbuf_r;
      end
      default: begin
        RF_ADDR = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_ctx_transfer_ctrl.sv
// Self-checking bench for reg_ctx_transfer_ctrl: register file and memory
// models with programmable wait states, scoreboard queues of expected
// memory writes and RF writes, directed steps in one initial block.
module tb_reg_ctx_transfer_ctrl;

  typedef logic [39:0] ev_t;

  logic        CLK;
  logic        RESET;
  logic        SAVE_REQ, RESTORE_REQ;
  logic [1:0]  CTX_ID;
  logic        BUSYWAIT, DONE, ERR;
  logic [4:0]  RF_ADDR;
  logic [31:0] RF_RDATA;
  logic        RF_WEN;
  logic [31:0] RF_WDATA;
  logic [7:0]  MEM_ADDR;
  logic        MEM_READ, MEM_WRITE;
  logic [31:0] MEM_WDATA, MEM_RDATA;
  logic        MEM_BUSYWAIT;

  // second instance built with NUM_CTX=3
  logic        b_save, b_rest;
  logic [1:0]  b_ctx;
  logic        b_busy, b_done, b_err, b_rfwen, b_mread, b_mwrite;
  logic [4:0]  b_rfaddr;
  logic [31:0] b_rfwdata, b_mwdata;
  logic [7:0]  b_maddr;

  logic [31:0] rf  [32];
  logic [31:0] mem [256];
  logic        rf_load, mem_load;
  logic [31:0] rf_base, mem_base;
  int          wait_n;
  int          wcnt = 0;

  int  n_checks = 0;
  int  n_fail   = 0;
  int  lat, acc_rd, acc_wr, rf_wen_n, both_n, err_n;
  bit  bw_ok;
  bit  quiet_bad;
  ev_t exp_wr[$];
  ev_t exp_rf[$];
  ev_t ev;

  reg_ctx_transfer_ctrl dut (
    .CLK(CLK), .RESET(RESET), .SAVE_REQ(SAVE_REQ), .RESTORE_REQ(RESTORE_REQ),
    .CTX_ID(CTX_ID), .BUSYWAIT(BUSYWAIT), .DONE(DONE), .ERR(ERR),
    .RF_ADDR(RF_ADDR), .RF_RDATA(RF_RDATA), .RF_WEN(RF_WEN), .RF_WDATA(RF_WDATA),
    .MEM_ADDR(MEM_ADDR), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  reg_ctx_transfer_ctrl #(.NUM_CTX(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .SAVE_REQ(b_save), .RESTORE_REQ(b_rest),
    .CTX_ID(b_ctx), .BUSYWAIT(b_busy), .DONE(b_done), .ERR(b_err),
    .RF_ADDR(b_rfaddr), .RF_RDATA(32'h0), .RF_WEN(b_rfwen), .RF_WDATA(b_rfwdata),
    .MEM_ADDR(b_maddr), .MEM_READ(b_mread), .MEM_WRITE(b_mwrite),
    .MEM_WDATA(b_mwdata), .MEM_RDATA(32'h0), .MEM_BUSYWAIT(1'b0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  assign RF_RDATA     = rf[RF_ADDR];
  assign MEM_RDATA    = mem[MEM_ADDR];
  assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (wcnt < wait_n);

  // Register file / memory models and wait-state counter.
  always @(posedge CLK) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_base + 32'(i);
    end else if (RF_WEN) begin
      rf[RF_ADDR] <= RF_WDATA;
    end
    if (mem_load) begin
      for (int a = 0; a < 256; a++) mem[a] <= mem_base + 32'(a);
    end else if (MEM_WRITE && !MEM_BUSYWAIT) begin
      mem[MEM_ADDR] <= MEM_WDATA;
    end
    if ((MEM_READ || MEM_WRITE) && (wcnt < wait_n)) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_models(input logic [31:0] rb, input logic [31:0] mb);
    rf_base  = rb;
    mem_base = mb;
    rf_load  = 1'b1;
    mem_load = 1'b1;
    @(negedge CLK);
    rf_load  = 1'b0;
    mem_load = 1'b0;
  endtask

  task automatic push_writes(input int ctx, input logic [31:0] base);
    for (int i = 1; i < 32; i++) exp_wr.push_back({8'(ctx * 32 + i), base + 32'(i)});
  endtask

  task automatic push_rf(input logic [31:0] base);
    for (int i = 1; i < 32; i++) exp_rf.push_back({8'(i), base + 32'(i)});
  endtask

  // Runs clock cycles (sampled at negedge+1) until DONE/ERR, a write count,
  // or the cycle budget; scoreboard outputs on the way.
  task automatic run(input int max_cyc, input bit hold, input int stop_wr);
    int edges;
    edges = 0;
    lat = -1; acc_rd = 0; acc_wr = 0; rf_wen_n = 0; both_n = 0; err_n = 0; bw_ok = 1'b1;
    while (edges < max_cyc) begin
      @(posedge CLK);
      edges++;
      @(negedge CLK);
      if (!hold) begin
        SAVE_REQ    = 1'b0;
        RESTORE_REQ = 1'b0;
        CTX_ID      = ~CTX_ID;
      end
      #1;
      if (MEM_READ && MEM_WRITE) both_n++;
      if (MEM_READ && !MEM_BUSYWAIT) acc_rd++;
      if (MEM_WRITE && !MEM_BUSYWAIT) begin
        acc_wr++;
        check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          ev = exp_wr.pop_front();
          check("mem_write", 64'({MEM_ADDR, MEM_WDATA}), 64'(ev));
        end
      end
      if (RF_WEN) begin
        rf_wen_n++;
        check("rf_expected", 64'(exp_rf.size() != 0), 64'd1);
        if (exp_rf.size() != 0) begin
          ev = exp_rf.pop_front();
          check("rf_write", 64'({3'b000, RF_ADDR, RF_WDATA}), 64'(ev));
        end
      end
      if (ERR) err_n++;
      if (DONE) begin
        lat = edges - 1;
        if (BUSYWAIT) bw_ok = 1'b0;
        break;
      end
      if (!BUSYWAIT) bw_ok = 1'b0;
      if (stop_wr != 0 && acc_wr == stop_wr) break;
    end
  endtask

  function automatic logic any_out();
    return |{BUSYWAIT, DONE, ERR, RF_ADDR, RF_WEN, RF_WDATA,
             MEM_ADDR, MEM_READ, MEM_WRITE, MEM_WDATA};
  endfunction

  initial begin
    RESET = 1'b1; SAVE_REQ = 1'b0; RESTORE_REQ = 1'b0; CTX_ID = 2'd0;
    b_save = 1'b0; b_rest = 1'b0; b_ctx = 2'd0;
    rf_load = 1'b0; mem_load = 1'b0; rf_base = 32'h0; mem_base = 32'h0; wait_n = 0;

    // reset state
    @(negedge CLK);
    load_models(32'h1000_0000, 32'hEE00_0000);
    #1;
    check("reset_outputs_zero", 64'(any_out()), 64'd0);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    check("idle_outputs_zero", 64'(any_out()), 64'd0);

    // save, zero-wait, context 2
    @(negedge CLK);
    push_writes(2, 32'h1000_0000);
    SAVE_REQ = 1'b1; CTX_ID = 2'd2;
    #1;
    check("save_req_cycle_busy", 64'(BUSYWAIT), 64'd1);
    run(200, 1'b0, 0);
    check("save_latency", 64'(lat), 64'd62);
    check("save_busywait", 64'(bw_ok), 64'd1);
    check("save_write_count", 64'(acc_wr), 64'd31);
    check("save_no_read", 64'(acc_rd), 64'd0);
    check("save_queue_drained", 64'(exp_wr.size()), 64'd0);
    @(negedge CLK);
    check("save_x0_untouched", 64'(mem[64]), 64'hEE00_0040);
    check("save_last_word", 64'(mem[95]), 64'h1000_001F);

    // restore with 3 wait states per read, context 1
    wait_n = 3;
    load_models(32'h5555_0000, 32'hA000_0000);
    push_rf(32'hA000_0020);
    RESTORE_REQ = 1'b1; CTX_ID = 2'd1;
    run(400, 1'b0, 0);
    check("rest_latency", 64'(lat), 64'd155);
    check("rest_rf_wen_count", 64'(rf_wen_n), 64'd31);
    check("rest_no_write", 64'(acc_wr), 64'd0);
    check("rest_queue_drained", 64'(exp_rf.size()), 64'd0);
    @(negedge CLK);
    check("rest_x0_untouched", 64'(rf[0]), 64'h5555_0000);
    check("rest_rf31", 64'(rf[31]), 64'hA000_003F);

    // simultaneous requests: restore wins
    wait_n = 0;
    load_models(32'h0, 32'h3C00_0000);
    push_rf(32'h3C00_0000);
    SAVE_REQ = 1'b1; RESTORE_REQ = 1'b1; CTX_ID = 2'd0;
    run(200, 1'b0, 0);
    check("both_latency", 64'(lat), 64'd62);
    check("both_no_write", 64'(acc_wr), 64'd0);
    check("both_reads", 64'(acc_rd), 64'd31);
    check("both_never_rw", 64'(both_n), 64'd0);
    check("both_queue_drained", 64'(exp_rf.size()), 64'd0);

    // asynchronous reset after 10th accepted write
    load_models(32'h7700_0000, 32'hEE00_0000);
    push_writes(3, 32'h7700_0000);
    SAVE_REQ = 1'b1; CTX_ID = 2'd3;
    run(200, 1'b0, 10);
    check("rst_ten_writes", 64'(acc_wr), 64'd10);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    check("rst_async_outputs_zero", 64'(any_out()), 64'd0);
    exp_wr.delete();
    @(negedge CLK);
    RESET = 1'b0;
    check("rst_tenth_written", 64'(mem[106]), 64'h7700_000A);
    check("rst_eleventh_not", 64'(mem[107]), 64'hEE00_006B);
    push_writes(3, 32'h7700_0000);
    SAVE_REQ = 1'b1; CTX_ID = 2'd3;
    run(200, 1'b0, 0);
    check("rst_restart_latency", 64'(lat), 64'd62);
    check("rst_restart_queue", 64'(exp_wr.size()), 64'd0);

    // request held through DONE
    @(negedge CLK);
    push_writes(0, 32'h7700_0000);
    SAVE_REQ = 1'b1; CTX_ID = 2'd0;
    run(200, 1'b1, 0);
    check("hold_latency", 64'(lat), 64'd62);
    check("hold_done_busy_low", 64'({DONE, BUSYWAIT}), 64'b10);
    @(posedge CLK);
    @(negedge CLK);
    #1;
    check("hold_ignored_in_done", 64'({BUSYWAIT, RF_ADDR}), 64'({1'b1, 5'd0}));
    push_writes(0, 32'h7700_0000);
    run(200, 1'b0, 0);
    check("hold_second_latency", 64'(lat), 64'd62);
    check("hold_second_count", 64'(acc_wr), 64'd31);
    check("hold_queue_drained", 64'(exp_wr.size()), 64'd0);

    // NUM_CTX=3 build: CTX_ID=3 rejected
    @(negedge CLK);
    b_save = 1'b1; b_ctx = 2'd3;
    #1;
    check("err_req_cycle_busy", 64'(b_busy), 64'd1);
    @(negedge CLK);
    #1;
    check("err_pulse", 64'({b_err, b_busy, b_done, b_mread, b_mwrite, b_rfwen}), 64'b100000);
    b_save = 1'b0;
    quiet_bad = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      #1;
      if (|{b_err, b_busy, b_done, b_mread, b_mwrite, b_rfwen,
            b_rfaddr, b_rfwdata, b_maddr, b_mwdata}) quiet_bad = 1'b1;
    end
    check("err_quiet_after", 64'(quiet_bad), 64'd0);
    b_save = 1'b1; b_ctx = 2'd2;
    @(negedge CLK);
    b_save = 1'b0;
    #1;
    check("err_back_to_idle", 64'({b_busy, b_rfaddr}), 64'({1'b1, 5'd1}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
